// File: rtl/intersection_phase_scheduler_if.sv
// Sensor/button inputs and lamp/walk outputs of the intersection phase scheduler.
// The controller side is the slave; the sensor front end and lamp drivers are the master.
interface intersection_phase_scheduler_if;
  logic       tick;
  logic [1:0] car_req;
  logic [1:0] ped_btn;
  logic       emerg_req;
  logic       emerg_dir;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ns_walk;
  logic       ew_walk;
  logic [1:0] ped_pend;

  modport master (
    output tick, car_req, ped_btn, emerg_req, emerg_dir,
    input  ns_light, ew_light, ns_walk, ew_walk, ped_pend
  );

  modport slave (
    input  tick, car_req, ped_btn, emerg_req, emerg_dir,
    output ns_light, ew_light, ns_walk, ew_walk, ped_pend
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven two-axis phase scheduler: GREEN -> YELLOW -> ALL_RED with
// min/max green, latched pedestrian requests and emergency preemption.
module intersection_phase_scheduler #(
  parameter int TW        = 4,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int WALK_T    = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  intersection_phase_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_t;

  localparam logic [TW-1:0] C_MIN_END = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] C_MAX_END = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] C_Y_END   = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] C_AR_END  = TW'(ALL_RED_T - 1);
  localparam logic [TW-1:0] C_WALK    = TW'(WALK_T);

  state_t        r_state, w_state_nxt;
  logic          r_dir, w_dir_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic [1:0]    r_ped_pend, w_ped_nxt;
  logic          r_walk_en, w_walk_en_nxt;
  logic [1:0]    w_dem;
  logic          w_opp;
  logic          w_go;
  logic          w_sel;
  logic          w_exit;
  logic          w_walk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_ALL_RED;
      r_dir      <= 1'b1;
      r_timer    <= '0;
      r_ped_pend <= '0;
      r_walk_en  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_timer    <= w_timer_nxt;
      r_ped_pend <= w_ped_nxt;
      r_walk_en  <= w_walk_en_nxt;
    end
  end

  always_comb begin
    w_dem         = bus.car_req | r_ped_pend;
    w_opp         = ~r_dir;
    w_timer_inc   = r_timer + TW'(1);
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_timer_nxt   = r_timer;
    w_walk_en_nxt = r_walk_en;
    w_ped_nxt     = r_ped_pend | bus.ped_btn;
    w_go          = 1'b0;
    w_sel         = r_dir;
    w_exit        = 1'b0;

    case (r_state)
      S_ALL_RED: begin
        if (bus.tick) begin
          if (r_timer == C_AR_END) begin
            if (bus.emerg_req) begin
              w_go  = 1'b1;
              w_sel = bus.emerg_dir;
            end else if (w_dem[w_opp]) begin
              w_go  = 1'b1;
              w_sel = w_opp;
            end else if (w_dem[r_dir]) begin
              w_go  = 1'b1;
              w_sel = r_dir;
            end
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
        // Entry clear overrides a press on the same edge: the new walk serves it.
        if (w_go) begin
          w_state_nxt      = S_GREEN;
          w_dir_nxt        = w_sel;
          w_timer_nxt      = '0;
          w_walk_en_nxt    = r_ped_pend[w_sel];
          w_ped_nxt[w_sel] = 1'b0;
        end
      end

      S_GREEN: begin
        w_exit = ((r_timer >= C_MIN_END) && !bus.car_req[r_dir] && w_dem[w_opp]) ||
                 ((r_timer >= C_MAX_END) && w_dem[w_opp]);
        if (bus.emerg_req) begin
          if (bus.emerg_dir != r_dir) begin
            w_state_nxt = S_YELLOW;
            w_timer_nxt = '0;
          end
        end else if (bus.tick) begin
          if (w_exit) begin
            w_state_nxt = S_YELLOW;
            w_timer_nxt = '0;
          end else if (r_timer < C_MAX_END) begin
            w_timer_nxt = w_timer_inc;
          end
        end
      end

      S_YELLOW: begin
        if (bus.tick) begin
          if (r_timer == C_Y_END) begin
            w_state_nxt = S_ALL_RED;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
      end

      default: begin
        w_state_nxt = S_ALL_RED;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign w_walk = (r_state == S_GREEN) && r_walk_en && (r_timer < C_WALK) && !bus.emerg_req;

  assign bus.ns_light = (r_state == S_GREEN  && !r_dir) ? 3'b001 :
                        (r_state == S_YELLOW && !r_dir) ? 3'b010 : 3'b100;
  assign bus.ew_light = (r_state == S_GREEN  &&  r_dir) ? 3'b001 :
                        (r_state == S_YELLOW &&  r_dir) ? 3'b010 : 3'b100;
  assign bus.ns_walk  = w_walk && !r_dir;
  assign bus.ew_walk  = w_walk &&  r_dir;
  assign bus.ped_pend = r_ped_pend;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scripted scoreboard bench for intersection_phase_scheduler: each driven cycle
// queues the lamp/walk/pending state expected right after the next clock edge.
module tb_intersection_phase_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;

  intersection_phase_scheduler_if bus();

  intersection_phase_scheduler #(
    .TW(4), .MIN_GREEN(4), .MAX_GREEN(12), .YELLOW_T(3), .ALL_RED_T(2), .WALK_T(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic [1:0] walk;  // {ew_walk, ns_walk}
    logic [1:0] pend;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input int n, input logic [1:0] car, input logic [1:0] ped,
                     input logic em, input logic tk, input logic [2:0] ns,
                     input logic [2:0] ew, input logic [1:0] wk, input logic [1:0] pd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.car_req   = car;
      bus.ped_btn   = ped;
      bus.emerg_req = em;
      bus.emerg_dir = 1'b0;
      bus.tick      = tk;
      q.push_back(exp_t'{ns, ew, wk, pd});
    end
  endtask

  task automatic release_reset(input logic [1:0] car);
    @(negedge clk);
    reset         = 1'b0;
    bus.car_req   = car;
    bus.ped_btn   = 2'b00;
    bus.emerg_req = 1'b0;
    bus.tick      = 1'b1;
    q.push_back(exp_t'{R, R, 2'b00, 2'b00});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ns"},   bus.ns_light, R);
    check({tag, "_ew"},   bus.ew_light, R);
    check({tag, "_walk"}, {bus.ew_walk, bus.ns_walk}, 2'b00);
    check({tag, "_pend"}, bus.ped_pend, 2'b00);
  endtask

  // Output monitor: scoreboard pops plus per-cycle safety invariants.
  initial begin
    exp_t e;
    logic seen_y, seen_clear, prev_ns_g, prev_ew_g, ns_g, ew_g;
    seen_y = 1'b0; seen_clear = 1'b1; prev_ns_g = 1'b0; prev_ew_g = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        seen_y = 1'b0; seen_clear = 1'b1; prev_ns_g = 1'b0; prev_ew_g = 1'b0;
      end else begin
        ns_g = (bus.ns_light == G);
        ew_g = (bus.ew_light == G);
        check("one_axis", (bus.ns_light != R) && (bus.ew_light != R), 0);
        check("ns_walk_green", bus.ns_walk && !ns_g, 0);
        check("ew_walk_green", bus.ew_walk && !ew_g, 0);
        if (bus.ns_light == Y || bus.ew_light == Y) seen_y = 1'b1;
        if (bus.ns_light == R && bus.ew_light == R && seen_y) seen_clear = 1'b1;
        if ((ns_g && !prev_ns_g) || (ew_g && !prev_ew_g)) begin
          check("green_seq", seen_clear, 1);
          seen_y = 1'b0; seen_clear = 1'b0;
        end
        prev_ns_g = ns_g;
        prev_ew_g = ew_g;
        if (q.size() > 0) begin
          e = q.pop_front();
          check("ns_light", bus.ns_light, e.ns);
          check("ew_light", bus.ew_light, e.ew);
          check("walk",     {bus.ew_walk, bus.ns_walk}, e.walk);
          check("ped_pend", bus.ped_pend, e.pend);
        end
      end
    end
  end

  initial begin
    bus.tick = 1'b1; bus.car_req = 2'b01; bus.ped_btn = 2'b00;
    bus.emerg_req = 1'b0; bus.emerg_dir = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");

    // 1: NS demand only -> 2 all-red cycles then NS rests green
    release_reset(2'b01);
    run(20, 2'b01, 2'b00, 0, 1, G, R, 2'b00, 2'b00);

    // 2: both demands -> max-out; tick=0 stretches yellow; full EW cycle
    run(1,  2'b11, 2'b00, 0, 1, Y, R, 2'b00, 2'b00);
    run(2,  2'b11, 2'b00, 0, 0, Y, R, 2'b00, 2'b00);
    run(2,  2'b11, 2'b00, 0, 1, Y, R, 2'b00, 2'b00);
    run(2,  2'b11, 2'b00, 0, 1, R, R, 2'b00, 2'b00);
    run(12, 2'b11, 2'b00, 0, 1, R, G, 2'b00, 2'b00);
    run(3,  2'b11, 2'b00, 0, 1, R, Y, 2'b00, 2'b00);
    run(2,  2'b11, 2'b00, 0, 1, R, R, 2'b00, 2'b00);

    // 3: NS car drops at green tick 1 -> gap-out at MIN_GREEN; EW gap-out too
    run(2,  2'b11, 2'b00, 0, 1, G, R, 2'b00, 2'b00);
    run(2,  2'b10, 2'b00, 0, 1, G, R, 2'b00, 2'b00);
    run(3,  2'b10, 2'b00, 0, 1, Y, R, 2'b00, 2'b00);
    run(2,  2'b10, 2'b00, 0, 1, R, R, 2'b00, 2'b00);
    run(3,  2'b10, 2'b00, 0, 1, R, G, 2'b00, 2'b00);
    run(1,  2'b01, 2'b00, 0, 1, R, G, 2'b00, 2'b00);
    run(3,  2'b01, 2'b00, 0, 1, R, Y, 2'b00, 2'b00);
    run(2,  2'b01, 2'b00, 0, 1, R, R, 2'b00, 2'b00);
    run(14, 2'b01, 2'b00, 0, 1, G, R, 2'b00, 2'b00);

    // 4: EW ped press while NS rests -> EW walk 5 ticks; press on entry edge is absorbed
    run(1,  2'b00, 2'b10, 0, 1, G, R, 2'b00, 2'b10);
    run(3,  2'b00, 2'b00, 0, 1, Y, R, 2'b00, 2'b10);
    run(2,  2'b00, 2'b00, 0, 1, R, R, 2'b00, 2'b10);
    run(1,  2'b00, 2'b10, 0, 1, R, G, 2'b10, 2'b00);
    run(4,  2'b00, 2'b00, 0, 1, R, G, 2'b10, 2'b00);
    run(3,  2'b00, 2'b00, 0, 1, R, G, 2'b00, 2'b00);

    // 5: NS preemption during EW green -> forced yellow, full clearance, NS held
    run(3,  2'b11, 2'b00, 1, 1, R, Y, 2'b00, 2'b00);
    run(2,  2'b11, 2'b00, 1, 1, R, R, 2'b00, 2'b00);
    run(15, 2'b11, 2'b00, 1, 1, G, R, 2'b00, 2'b00);
    run(11, 2'b11, 2'b00, 0, 1, G, R, 2'b00, 2'b00);
    run(1,  2'b11, 2'b10, 0, 1, Y, R, 2'b00, 2'b10);

    // 6: asynchronous reset mid-yellow, then restart as in 1
    @(negedge clk);
    reset = 1'b1;
    bus.car_req = 2'b01;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    release_reset(2'b01);
    run(5,  2'b01, 2'b00, 0, 1, G, R, 2'b00, 2'b00);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
